// File: rtl/cpu_mem_pkg.sv
// Shared types and constants for the CPU data-memory responder.
package cpu_mem_pkg;

    localparam int CPU_ADDR_W = 16;
    localparam int DATA_W_DEF = 16;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_e;

    // A CPU word address is implemented only if every bit above the array index is zero.
    function automatic logic addr_in_range(input logic [CPU_ADDR_W-1:0] addr, input int aw);
        return (addr >> aw) == '0;
    endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// Request/response channel between the CPU-side initiator and the data-memory responder.
interface data_mem_responder_if
    import cpu_mem_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [CPU_ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0]     req_wdata;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_W-1:0]     rsp_rdata;
    logic                  rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/data_mem_responder_sp_ram.sv
// Single-port word array: synchronous write, registered read, no reset on contents.
module sp_ram #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem_q [2**ADDR_W];
    logic [DATA_W-1:0] rdata_q;

    // Read data holds its last value while the port is idle.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem_q[addr] <= wdata;
            end else begin
                rdata_q <= mem_q[addr];
            end
        end
    end

    assign rdata = rdata_q;
endmodule

// File: rtl/data_mem_responder.sv
// Responder end of the CPU data-memory interface: one request at a time with
// programmable wait states, backed by a single-port synchronous RAM.
module data_mem_responder
    import cpu_mem_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    data_mem_responder_if.slave  bus
);
    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              ready_q, ready_d;
    logic              we_q, we_d;
    logic              err_q, err_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;

    logic              accept;
    logic              ram_en;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

    assign accept = (state_q == IDLE) && ready_q && bus.req_valid;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        we_d      = we_q;
        err_d     = err_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        ram_en    = 1'b0;
        ram_we    = we_q;
        ram_addr  = addr_q;
        ram_wdata = wdata_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    we_d    = bus.req_we;
                    err_d   = !addr_in_range(bus.req_addr, ADDR_W);
                    addr_d  = bus.req_addr[ADDR_W-1:0];
                    wdata_d = bus.req_wdata;
                    cnt_d   = 4'(WAIT_CYCLES);
                    if (WAIT_CYCLES == 0) begin
                        // Zero wait states: access the array on the accept edge from the live request.
                        state_d   = RESP;
                        ram_en    = addr_in_range(bus.req_addr, ADDR_W);
                        ram_we    = bus.req_we;
                        ram_addr  = bus.req_addr[ADDR_W-1:0];
                        ram_wdata = bus.req_wdata;
                    end else begin
                        state_d = ACCESS;
                    end
                end
            end
            ACCESS: begin
                if (cnt_q <= 4'd1) begin
                    cnt_d   = 4'd0;
                    ram_en  = !err_q;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
        end
    end

    // Request registers carry data only; they are qualified by state, so no reset is needed.
    always_ff @(posedge clk) begin
        we_q    <= we_d;
        err_q   <= err_d;
        addr_q  <= addr_d;
        wdata_q <= wdata_d;
    end

    // Reset suppresses the array access so an abandoned write never commits.
    sp_ram #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_ram (
        .clk   (clk),
        .en    (ram_en && !reset),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    assign bus.req_ready = ready_q;
    assign bus.rsp_valid = (state_q == RESP);
    assign bus.rsp_err   = (state_q == RESP) && err_q;
    assign bus.rsp_rdata = ((state_q == RESP) && !we_q && !err_q) ? ram_rdata : '0;
endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: one instance with two wait states, one with none.
module tb_data_mem_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        sel;
    logic        valid;
    logic        we;
    logic        rsp_ready;
    logic [15:0] addr;
    logic [15:0] wdata;

    logic        o_ready;
    logic        o_rsp_valid;
    logic [15:0] o_rdata;
    logic        o_err;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    data_mem_responder_if #(.DATA_W(16)) ifa ();
    data_mem_responder_if #(.DATA_W(16)) ifb ();

    assign ifa.req_valid = valid & ~sel;
    assign ifa.req_we    = we;
    assign ifa.req_addr  = addr;
    assign ifa.req_wdata = wdata;
    assign ifa.rsp_ready = rsp_ready & ~sel;

    assign ifb.req_valid = valid & sel;
    assign ifb.req_we    = we;
    assign ifb.req_addr  = addr;
    assign ifb.req_wdata = wdata;
    assign ifb.rsp_ready = rsp_ready & sel;

    assign o_ready     = sel ? ifb.req_ready : ifa.req_ready;
    assign o_rsp_valid = sel ? ifb.rsp_valid : ifa.rsp_valid;
    assign o_rdata     = sel ? ifb.rsp_rdata : ifa.rsp_rdata;
    assign o_err       = sel ? ifb.rsp_err   : ifa.rsp_err;

    data_mem_responder #(.ADDR_W(8), .DATA_W(16), .WAIT_CYCLES(2)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (ifa.slave)
    );

    data_mem_responder #(.ADDR_W(8), .DATA_W(16), .WAIT_CYCLES(0)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (ifb.slave)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One transaction; request inputs are scrambled right after accept.
    task automatic xfer(input logic s, input logic w, input logic [15:0] a, input logic [15:0] d,
                        input int hold, output logic [15:0] rd, output logic er,
                        output int lat, output int low);
        int n;
        sel       = s;
        rsp_ready = (hold == 0);
        n = 0;
        while (!o_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("rdy_wait", {31'd0, o_ready}, 32'd1);
        we = w; addr = a; wdata = d; valid = 1'b1;
        @(posedge clk); #1;
        valid = 1'b0; we = ~w; addr = 16'h00FF; wdata = 16'hDEAD;
        lat = 1;
        low = 0;
        while (1) begin
            if (!o_ready) low++;
            if (o_rsp_valid || lat >= 40) break;
            @(posedge clk); #1;
            lat++;
        end
        chk("rsp_seen", {31'd0, o_rsp_valid}, 32'd1);
        rd = o_rdata;
        er = o_err;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            if (!o_ready) low++;
            chk("hold_vld", {31'd0, o_rsp_valid}, 32'd1);
            chk("hold_rd", {16'd0, o_rdata}, {16'd0, rd});
            chk("hold_err", {31'd0, o_err}, {31'd0, er});
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        chk("rdy_back", {31'd0, o_ready}, 32'd1);
        chk("vld_drop", {31'd0, o_rsp_valid}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] rd;
        logic        er;
        int          lat;
        int          low;

        reset = 1'b1; sel = 1'b0; valid = 1'b0; we = 1'b0;
        addr = 16'h0; wdata = 16'h0; rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", {31'd0, o_ready}, 32'd0);
        chk("rst_valid", {31'd0, o_rsp_valid}, 32'd0);
        chk("rst_rdata", {16'd0, o_rdata}, 32'd0);
        chk("rst_err", {31'd0, o_err}, 32'd0);
        reset = 1'b0;

        xfer(1'b0, 1'b1, 16'h00FF, 16'h0F0F, 0, rd, er, lat, low);

        // Two wait states: write then read back, three cycles each.
        xfer(1'b0, 1'b1, 16'h0005, 16'hBEEF, 0, rd, er, lat, low);
        chk("t1_w_lat", lat, 3);
        chk("t1_w_rd", {16'd0, rd}, 32'h0);
        chk("t1_w_err", {31'd0, er}, 32'd0);
        chk("t1_w_low", low, 3);
        xfer(1'b0, 1'b0, 16'h0005, 16'h0000, 0, rd, er, lat, low);
        chk("t1_r_lat", lat, 3);
        chk("t1_r_rd", {16'd0, rd}, 32'hBEEF);
        chk("t1_r_err", {31'd0, er}, 32'd0);

        // Zero wait states: response in the cycle after accept, single bubble.
        xfer(1'b1, 1'b1, 16'h0005, 16'hBEEF, 0, rd, er, lat, low);
        chk("t2_w_lat", lat, 1);
        chk("t2_w_rd", {16'd0, rd}, 32'h0);
        xfer(1'b1, 1'b0, 16'h0005, 16'h0000, 0, rd, er, lat, low);
        chk("t2_r_lat", lat, 1);
        chk("t2_r_rd", {16'd0, rd}, 32'hBEEF);
        chk("t2_r_low", low, 1);
        xfer(1'b1, 1'b1, 16'h0020, 16'h1111, 0, rd, er, lat, low);
        xfer(1'b1, 1'b0, 16'h0020, 16'h0000, 0, rd, er, lat, low);
        chk("t2_mut_rd", {16'd0, rd}, 32'h1111);

        // Out-of-range accesses.
        xfer(1'b0, 1'b1, 16'h0000, 16'h0042, 0, rd, er, lat, low);
        xfer(1'b0, 1'b0, 16'h0100, 16'h0000, 0, rd, er, lat, low);
        chk("t3_r_err", {31'd0, er}, 32'd1);
        chk("t3_r_rd", {16'd0, rd}, 32'h0);
        xfer(1'b0, 1'b1, 16'h0100, 16'h7777, 0, rd, er, lat, low);
        chk("t3_w_err", {31'd0, er}, 32'd1);
        chk("t3_w_rd", {16'd0, rd}, 32'h0);
        xfer(1'b0, 1'b0, 16'h0000, 16'h0000, 0, rd, er, lat, low);
        chk("t3_mem0", {16'd0, rd}, 32'h0042);
        chk("t3_mem0_err", {31'd0, er}, 32'd0);

        // Response backpressure for five cycles.
        xfer(1'b0, 1'b1, 16'h0033, 16'h1234, 0, rd, er, lat, low);
        xfer(1'b0, 1'b0, 16'h0033, 16'h0000, 5, rd, er, lat, low);
        chk("t4_rd", {16'd0, rd}, 32'h1234);
        chk("t4_err", {31'd0, er}, 32'd0);

        // Reset during ACCESS abandons the write.
        xfer(1'b0, 1'b1, 16'h00AA, 16'h0001, 0, rd, er, lat, low);
        sel = 1'b0;
        chk("t5_rdy", {31'd0, o_ready}, 32'd1);
        we = 1'b1; addr = 16'h00AA; wdata = 16'h5555; valid = 1'b1;
        @(posedge clk); #1;
        valid = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        chk("t5_ready", {31'd0, o_ready}, 32'd0);
        chk("t5_valid", {31'd0, o_rsp_valid}, 32'd0);
        chk("t5_rdata", {16'd0, o_rdata}, 32'd0);
        chk("t5_err", {31'd0, o_err}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("t5_valid2", {31'd0, o_rsp_valid}, 32'd0);
        reset = 1'b0;
        xfer(1'b0, 1'b0, 16'h00AA, 16'h0000, 0, rd, er, lat, low);
        chk("t5_mem", {16'd0, rd}, 32'h0001);

        // Inputs changed after accept must not leak into the transaction.
        xfer(1'b0, 1'b1, 16'h0010, 16'hA5A5, 0, rd, er, lat, low);
        xfer(1'b0, 1'b0, 16'h0010, 16'h0000, 0, rd, er, lat, low);
        chk("t6_rd", {16'd0, rd}, 32'hA5A5);
        xfer(1'b0, 1'b0, 16'h00FF, 16'h0000, 0, rd, er, lat, low);
        chk("t6_ff", {16'd0, rd}, 32'h0F0F);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
